// File: rtl/encoder_83_pkg.sv
// Shared widths, result type and reset value for the registered 8-to-3 priority encoder.
package encoder_83_pkg;

  localparam int unsigned IN_W  = 8;
  localparam int unsigned OUT_W = 3;

  typedef struct packed {
    logic [OUT_W-1:0] idx;
    logic             valid;
    logic             multi;
  } encResult_t;

  localparam encResult_t RESULT_RST = '{idx: '0, valid: 1'b0, multi: 1'b0};

endpackage

// File: rtl/encoder_83_core.sv
// Combinational priority encode of a request vector into index, valid and multiple-hot flags.
module encoder_83_core
  import encoder_83_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic [IN_W-1:0] iData,
  output encResult_t      oResult
);

  logic [OUT_W-1:0] winIdx;

  // The last match in scan order wins, so the scan direction sets the priority.
  always_comb begin
    winIdx = '0;
    if (PRIORITY_HIGH) begin
      for (int i = 0; i < IN_W; i++) begin
        if (iData[i]) winIdx = OUT_W'(i);
      end
    end else begin
      for (int i = IN_W - 1; i >= 0; i--) begin
        if (iData[i]) winIdx = OUT_W'(i);
      end
    end
  end

  always_comb begin
    oResult       = RESULT_RST;
    oResult.idx   = winIdx;
    oResult.valid = |iData;
    // Clearing the lowest set bit leaves something only when two or more bits were set.
    oResult.multi = |(iData & (iData - IN_W'(1)));
  end

endmodule

// File: rtl/encoder_83.sv
// Registered 8-to-3 priority encoder: one-cycle latency, asynchronous active-low reset.
module encoder_83
  import encoder_83_pkg::*;
#(
  parameter bit PRIORITY_HIGH = 1'b1
) (
  input  logic             iClk,
  input  logic             iRst_n,
  input  logic [IN_W-1:0]  iData,
  output logic [OUT_W-1:0] oData,
  output logic             oValid,
  output logic             oMulti
);

  encResult_t resultD;
  encResult_t resultQ;

  encoder_83_core #(
    .PRIORITY_HIGH(PRIORITY_HIGH)
  ) uCore (
    .iData  (iData),
    .oResult(resultD)
  );

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      resultQ <= RESULT_RST;
    end else begin
      resultQ <= resultD;
    end
  end

  assign oData  = resultQ.idx;
  assign oValid = resultQ.valid;
  assign oMulti = resultQ.multi;

endmodule

// File: tb/tb_encoder_83.sv
// Bench for encoder_83: both priority settings side by side against an arithmetic reference.
module tb_encoder_83;

  logic       iClk;
  logic       iRst_n;
  logic [7:0] iData;
  logic [2:0] hiData, loData;
  logic       hiValid, loValid, hiMulti, loMulti;

  int nCmp = 0;
  int nBad = 0;

  encoder_83 #(.PRIORITY_HIGH(1'b1)) uDutHi (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iData (iData),
    .oData (hiData),
    .oValid(hiValid),
    .oMulti(hiMulti)
  );

  encoder_83 #(.PRIORITY_HIGH(1'b0)) uDutLo (
    .iClk  (iClk),
    .iRst_n(iRst_n),
    .iData (iData),
    .oData (loData),
    .oValid(loValid),
    .oMulti(loMulti)
  );

  initial iClk = 1'b0;
  always #5 iClk = ~iClk;

  // Reference: {idx, valid, multi} from floor(log2) of the vector or of its lowest set bit.
  function automatic logic [4:0] model(input logic [7:0] v, input bit high);
    int unsigned x;
    int unsigned idx;
    x = 32'(v);
    if (x == 0) idx = 0;
    else if (high) idx = $clog2(x + 1) - 1;
    else idx = $clog2((x & (~x + 1)) + 1) - 1;
    return {idx[2:0], x != 0, $countones(v) > 1};
  endfunction

  task automatic checkVal(input string tag, input logic [4:0] expHi, input logic [4:0] expLo);
    nCmp++;
    assert ({hiData, hiValid, hiMulti} === expHi) else begin
      nBad++;
      $error("FAIL %s/high: observed %b expected %b", tag, {hiData, hiValid, hiMulti}, expHi);
    end
    nCmp++;
    assert ({loData, loValid, loMulti} === expLo) else begin
      nBad++;
      $error("FAIL %s/low: observed %b expected %b", tag, {loData, loValid, loMulti}, expLo);
    end
  endtask

  task automatic checkVec(input string tag, input logic [7:0] v);
    checkVal(tag, model(v, 1'b1), model(v, 1'b0));
  endtask

  task automatic step(input string tag, input logic [7:0] v);
    iData = v;
    @(posedge iClk);
    #1;
    checkVec(tag, v);
  endtask

  logic [7:0] vec;

  initial begin
    // Reset asserted from time zero with all requests set: outputs cleared before any edge.
    iRst_n = 1'b0;
    iData  = 8'hFF;
    #2;
    checkVal("reset_pre_edge", 5'b0, 5'b0);
    repeat (2) @(posedge iClk);
    #1;
    checkVal("reset_hold", 5'b0, 5'b0);
    #3 iRst_n = 1'b1;

    // First edge after release encodes normally.
    step("release_first", 8'h00);

    for (int i = 0; i < 8; i++) begin
      vec = 8'h01 << i;
      step($sformatf("onehot_%0d", i), vec);
      nCmp++;
      assert (hiData === 3'(i) && hiValid === 1'b1 && hiMulti === 1'b0) else begin
        nBad++;
        $error("FAIL onehot_code_%0d: observed %0d expected %0d", i, hiData, i);
      end
    end

    step("prio_a6", 8'b1010_0110);
    checkVal("prio_a6_fixed", {3'd7, 2'b11}, {3'd1, 2'b11});
    step("prio_ff", 8'hFF);
    checkVal("prio_ff_fixed", {3'd7, 2'b11}, {3'd0, 2'b11});
    step("prio_80", 8'h80);
    checkVal("prio_80_fixed", {3'd7, 2'b10}, {3'd7, 2'b10});

    // Inputs wiggling between edges must not reach the outputs until the next edge.
    step("glitch_base", 8'h04);
    for (int k = 0; k < 5; k++) begin
      iData = 8'(k * 37 + 9);
      #1;
      checkVec("glitch_hold", 8'h04);
    end
    iData = 8'h30;
    @(posedge iClk);
    #1;
    checkVec("glitch_last", 8'h30);

    // Mid-stream reset pulse between edges.
    step("stream_10", 8'h10);
    step("stream_40", 8'h40);
    #2 iRst_n = 1'b0;
    #1;
    checkVal("midreset_clear", 5'b0, 5'b0);
    iData = 8'h08;
    #1 iRst_n = 1'b1;
    @(posedge iClk);
    #1;
    checkVal("midreset_resume", {3'd3, 2'b10}, {3'd3, 2'b10});

    for (int n = 0; n < 200; n++) begin
      step("random", 8'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule

// File: doc/encoder_83.md
# encoder_83

Registered 8-to-3 priority encoder. Converts an 8-bit request vector into the 3-bit index of the winning set bit, with a valid flag and a multiple-hot flag. Used wherever a one-hot or request vector must be reduced to a binary index, e.g. interrupt or arbitration front-ends feeding binary-indexed logic.

## Interface
- PRIORITY_HIGH, default 1: 1 = highest-numbered set bit wins; 0 = lowest-numbered set bit wins.
- iClk  input  1  clock; all outputs update on its rising edge.
- iRst_n  input  1  asynchronous, active-low reset.
- iData  input  8  request vector; bit n set means index n is requested.
- oData  output  3  binary index of the winning bit; registered.
- oValid  output  1  1 when at least one bit of the sampled iData was set; registered.
- oMulti  output  1  1 when two or more bits of the sampled iData were set; registered.

## Operation
- Each rising iClk samples iData and registers the encode result.
- One-hot input, bit n set: oData = n, oValid = 1, oMulti = 0.
  - Required codes: 8'h01→0, 8'h02→1, 8'h04→2, 8'h08→3, 8'h10→4, 8'h20→5, 8'h40→6, 8'h80→7.
- All-zero input: oData = 3'd0, oValid = 0, oMulti = 0.
  - oData = 0 is also the code for bit 0. oValid is the only way to tell the two cases apart.
- Multiple bits set:
  - oMulti = 1, oValid = 1.
  - PRIORITY_HIGH = 1: oData = index of the highest set bit.
  - PRIORITY_HIGH = 0: oData = index of the lowest set bit.
- Decode is purely a function of the iData sampled at that edge. No state is carried between cycles.
- iData is expected to be synchronous to iClk. No internal synchronizer.

## Timing
- Latency: exactly 1 cycle. Outputs after rising edge k reflect iData sampled at edge k.
- Throughput: one new vector per cycle, with no stall and no handshake.
- Reset:
  - iRst_n low forces oData = 3'd0, oValid = 0, oMulti = 0 immediately, without waiting for an iClk edge.
  - The outputs hold those values while iRst_n stays low.
- Reset release:
  - The first rising edge after iRst_n goes high samples iData normally.
  - No extra warm-up cycle.
- Reset asserted mid-stream: outputs clear at once. Any vector sampled before the reset is not reproduced after it.
- iData changing between edges has no effect on the outputs. Only the values present at rising edges matter.

## Structure
- Shared package encoder_83_pkg:
  - IN_W = 8 and OUT_W = 3.
  - Typedef for the result struct {idx, valid, multi}.
  - The reset value constant (all zeros).
- Sub-module encoder_83_core holds the combinational logic:
  - Maps iData to the result struct.
  - Parameterized by PRIORITY_HIGH.
  - Contains the priority logic and the popcount-greater-than-1 detect.
- Top level encoder_83:
  - Instantiates encoder_83_core.
  - Holds the single output register bank with the asynchronous active-low reset.

## Test plan
- Reset: iRst_n = 0 with iData = 8'hFF → oData = 0, oValid = 0, oMulti = 0 before any iClk edge. Outputs hold these values while reset stays low.
- One-hot sweep: drive 8'h00, then 8'h01, 8'h02, 8'h04 … 8'h80, one per cycle.
  - 8'h00 → oValid = 0.
  - Then oData = 0,1,2…7 each one cycle later, with oValid = 1 and oMulti = 0 throughout.
- Priority, PRIORITY_HIGH = 1:
  - 8'b1010_0110 → oData = 7, oValid = 1, oMulti = 1.
  - 8'hFF → oData = 7, oMulti = 1.
- Priority, PRIORITY_HIGH = 0:
  - 8'b1010_0110 → oData = 1, oMulti = 1.
  - 8'h80 → oData = 7, oMulti = 0.
- Latency and glitch check: change iData several times between two edges. Outputs change only at the edge, and reflect the last value sampled.
- Mid-stream reset: stream 8'h10 then 8'h40. Pulse iRst_n low between edges → outputs clear at once. The next edge after release encodes the current iData (8'h08 → oData = 3).
